// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface: hazard-detection inputs from ID/EX and
// front-end sequencing controls back to PC, IF_ID and ID/EX.
interface hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       branch_taken;
   logic       muldiv_start;
   logic       imem_ready;
   logic       pc_write;
   logic       ifid_hold;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       muldiv_busy;

   // pipeline side: reports hazard sources, consumes controls
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             branch_taken, muldiv_start, imem_ready,
      input  pc_write, ifid_hold, ifid_flush, idex_bubble, muldiv_busy
   );

   // controller side
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             branch_taken, muldiv_start, imem_ready,
      output pc_write, ifid_hold, ifid_flush, idex_bubble, muldiv_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Front-end hazard controller: load-use stall, mul/div freeze, taken-branch
// squash, plus saturating stall/flush counters. Controls are Mealy so a
// hazard is handled in the same cycle it is seen.
module hazard_ctrl #(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN, MD_BUSY} state_t;

   // a one-cycle mul/div is fully covered by its start cycle
   localparam bit        MD_MULTI = (MULDIV_CYCLES > 1);
   localparam logic [7:0] MD_INIT = 8'(MULDIV_CYCLES - 1);

   state_t     state;
   logic [7:0] md_cnt;
   logic       load_use;
   logic       branch_ok;

   // load in EX writes a register the ID instruction reads (r0 never hazards)
   always_comb begin
      load_use = hz.ex_mem_read && (hz.ex_rt != '0) &&
                 ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
   end

   // control decode; reset forces a bubble/flush so nothing leaks into the pipe
   always_comb begin
      hz.pc_write    = 1'b1;
      hz.ifid_hold   = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b0;
      branch_ok      = 1'b0;
      if (!reset) begin
         hz.pc_write    = 1'b0;
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (state == MD_BUSY) begin
         hz.pc_write    = 1'b0;
         hz.ifid_hold   = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (hz.branch_taken) begin
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
         branch_ok      = 1'b1;
      end else if (hz.muldiv_start || load_use) begin
         hz.pc_write    = 1'b0;
         hz.ifid_hold   = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (!hz.imem_ready) begin
         // no fetch word: IF_ID gets a bubble, the back end keeps draining
         hz.pc_write    = 1'b0;
         hz.ifid_flush  = 1'b1;
      end
   end

   // state register, so busy is glitch-free
   always_comb hz.muldiv_busy = (state == MD_BUSY);

   // mul/div occupancy FSM; the start cycle is spent in RUN, the rest in MD_BUSY
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!hz.branch_taken && hz.muldiv_start && MD_MULTI) begin
                  state  <= MD_BUSY;
                  md_cnt <= MD_INIT;
               end
            end
            MD_BUSY: begin
               if (md_cnt == 8'd1) begin
                  state  <= RUN;
                  md_cnt <= '0;
               end else begin
                  md_cnt <= md_cnt - 8'd1;
               end
            end
            default: begin
               state  <= RUN;
               md_cnt <= '0;
            end
         endcase
      end
   end

   // saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!hz.pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (branch_ok && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule
